// File: rtl/dpram_pkg.sv
// Shared defaults and helpers for the dpram read-side controller.
// Tag support is compiled in only when DPRAM_RD_CTRL_TAG_EN is defined.
package dpram_pkg;

    localparam int DPRAM_ADDR_W     = 10;
    localparam int DPRAM_DATA_W     = 64;
    localparam int DPRAM_FIFO_DEPTH = 4;
    localparam int DPRAM_TAG_W      = 4;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Pointers wrap naturally, so the depth must be a power of two.
    function automatic bit depth_ok(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

    typedef struct packed {
`ifdef DPRAM_RD_CTRL_TAG_EN
        logic [DPRAM_TAG_W-1:0]  tag;
`endif
        logic [DPRAM_DATA_W-1:0] data;
    } resp_entry_t;

endpackage

// File: rtl/dpram_rd_ctrl_if.sv
// Consumer request/response and dpram read-port signals of dpram_rd_ctrl.
// Tag signals exist only when DPRAM_RD_CTRL_TAG_EN is defined.
interface dpram_rd_ctrl_if
    import dpram_pkg::*;
#(
    parameter int ADDR_WIDTH = DPRAM_ADDR_W,
    parameter int DATA_WIDTH = DPRAM_DATA_W,
    parameter int TAG_WIDTH  = DPRAM_TAG_W
);
    logic                  REQ_VALID;
    logic                  REQ_READY;
    logic [ADDR_WIDTH-1:0] REQ_ADDR;
    logic                  ARVALID;
    logic [ADDR_WIDTH-1:0] ARADDR;
    logic                  RVALID;
    logic [DATA_WIDTH-1:0] RDATA;
    logic                  RESP_VALID;
    logic                  RESP_READY;
    logic [DATA_WIDTH-1:0] RESP_DATA;
`ifdef DPRAM_RD_CTRL_TAG_EN
    logic [TAG_WIDTH-1:0]  REQ_TAG;
    logic [TAG_WIDTH-1:0]  RESP_TAG;
`endif

    if (TAG_WIDTH < 1) begin : g_bad_tag_width
        $error("dpram_rd_ctrl_if: TAG_WIDTH must be at least 1");
    end

    modport slave (
`ifdef DPRAM_RD_CTRL_TAG_EN
        input  REQ_TAG,
        output RESP_TAG,
`endif
        input  REQ_VALID, REQ_ADDR, RVALID, RDATA, RESP_READY,
        output REQ_READY, ARVALID, ARADDR, RESP_VALID, RESP_DATA
    );

    modport master (
`ifdef DPRAM_RD_CTRL_TAG_EN
        output REQ_TAG,
        input  RESP_TAG,
`endif
        output REQ_VALID, REQ_ADDR, RVALID, RDATA, RESP_READY,
        input  REQ_READY, ARVALID, ARADDR, RESP_VALID, RESP_DATA
    );

endinterface

// File: rtl/dpram_rd_ctrl_sync_fifo.sv
// Synchronous power-of-two FIFO holding returned read responses.
// Pointers wrap naturally; the count is one bit wider to distinguish full from empty.
module sync_fifo
    import dpram_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int PTR_W = clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves it unassigned and infers a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
        if (!RESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; count_q keeps unwritten entries from being presented.
    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr_q] <= push_data;
    end

    assign pop_data = mem[rd_ptr_q];
    assign count    = count_q;
    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);

endmodule

// File: rtl/dpram_rd_ctrl.sv
// Read-side controller between a consumer and the dpram read port, with space-reserved response FIFO.
// Optional request tags are carried through when DPRAM_RD_CTRL_TAG_EN is defined.
module dpram_rd_ctrl
    import dpram_pkg::*;
#(
    parameter  int ADDR_WIDTH = DPRAM_ADDR_W,
    parameter  int DATA_WIDTH = DPRAM_DATA_W,
    parameter  int FIFO_DEPTH = DPRAM_FIFO_DEPTH,
    parameter  int TAG_WIDTH  = DPRAM_TAG_W,
    localparam int CNT_W      = clog2(FIFO_DEPTH) + 1
) (
    input  logic              CLK,
    input  logic              RESET,
    dpram_rd_ctrl_if.slave    bus,
    output logic [CNT_W-1:0]  OCCUPANCY,
    output logic              ERR_UNEXP
);

    typedef struct packed {
`ifdef DPRAM_RD_CTRL_TAG_EN
        logic [TAG_WIDTH-1:0]  tag;
`endif
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    if (!depth_ok(FIFO_DEPTH)) begin : g_bad_depth
        $error("dpram_rd_ctrl: FIFO_DEPTH must be a power of two and at least 2");
    end
    if (TAG_WIDTH < 1) begin : g_bad_tag_width
        $error("dpram_rd_ctrl: TAG_WIDTH must be at least 1");
    end

    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  inflight_q, inflight_d;
    logic                  err_q, err_d;
    logic                  accept, req_ready, resp_valid;
    logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CNT_W-1:0]      fifo_count, occupancy;
    entry_t                push_entry, head_entry;
`ifdef DPRAM_RD_CTRL_TAG_EN
    logic [TAG_WIDTH-1:0]  tag_q, tag_d;
`endif

    always_comb begin
        // A slot is reserved for the in-flight read so its data always has room when it returns.
        occupancy       = fifo_count + CNT_W'(inflight_q);
        req_ready       = (occupancy < CNT_W'(FIFO_DEPTH));
        accept          = bus.REQ_VALID & req_ready;
        resp_valid      = !fifo_empty;
        fifo_pop        = resp_valid & bus.RESP_READY;
        fifo_push       = bus.RVALID & inflight_q;
        inflight_d      = accept;
        err_d           = err_q | (bus.RVALID & !inflight_q);
        push_entry.data = bus.RDATA;
`ifdef DPRAM_RD_CTRL_TAG_EN
        push_entry.tag  = tag_q;
        tag_d           = accept ? bus.REQ_TAG : tag_q;
`endif
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            inflight_q <= 1'b0;
            err_q      <= 1'b0;
`ifdef DPRAM_RD_CTRL_TAG_EN
            tag_q      <= '0;
`endif
        end else begin
            inflight_q <= inflight_d;
            err_q      <= err_d;
`ifdef DPRAM_RD_CTRL_TAG_EN
            tag_q      <= tag_d;
`endif
        end
    end

    always_comb begin
        assert (!(fifo_push && fifo_full));
    end

    sync_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_resp_fifo (
        .CLK       (CLK),
        .RESET     (RESET),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .pop_data  (head_entry),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign req_addr       = bus.REQ_ADDR;
    assign bus.ARADDR     = req_addr;
    assign bus.ARVALID    = accept;
    assign bus.REQ_READY  = req_ready;
    assign bus.RESP_VALID = resp_valid;
    assign bus.RESP_DATA  = head_entry.data;
`ifdef DPRAM_RD_CTRL_TAG_EN
    assign bus.RESP_TAG   = head_entry.tag;
`endif
    assign OCCUPANCY      = occupancy;
    assign ERR_UNEXP      = err_q;

endmodule

// File: tb/tb_dpram_rd_ctrl.sv
// Randomised bench for dpram_rd_ctrl against a transaction-level model of accepted reads.
// Build with DPRAM_RD_CTRL_TAG_EN defined to also check tag ordering.
module tb_dpram_rd_ctrl;
    import dpram_pkg::*;

    localparam int AW    = 10;
    localparam int DW    = 64;
    localparam int TW    = 4;
    localparam int DEPTH = 4;
    localparam int CNT_W = clog2(DEPTH) + 1;

    logic             CLK = 1'b0;
    logic             RESET;
    logic [CNT_W-1:0] occupancy;
    logic             err_unexp;

    always #5 CLK = ~CLK;

    dpram_rd_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW)) bus ();

    dpram_rd_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH),
        .TAG_WIDTH  (TW)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .bus       (bus.slave),
        .OCCUPANCY (occupancy),
        .ERR_UNEXP (err_unexp)
    );

    // Behavioural dpram read port: fixed one-cycle latency.
    logic [DW-1:0] mem [1 << AW];
    logic          ram_rv_q = 1'b0;
    logic [DW-1:0] ram_rd_q = '0;
    logic          inj_rv;

    always @(posedge CLK) begin
        ram_rv_q <= bus.ARVALID;
        ram_rd_q <= mem[bus.ARADDR];
    end

    assign bus.RVALID = ram_rv_q | inj_rv;
    assign bus.RDATA  = ram_rd_q;

    // Reference model: every accepted read is owed one response, in order, visible two cycles later.
    typedef struct {
        resp_entry_t ent;
        int          vis;
    } exp_t;

    exp_t q[$];
    int   occ;
    int   cyc;
    bit   exp_err;
    bit   last_acc;
    int   arv_cnt;
    int   n_checks;
    int   n_errors;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        occ      = 0;
        cyc      = 0;
        exp_err  = 1'b0;
        last_acc = 1'b0;
    endtask

    // Called at a falling edge: checks registered outputs, drives the next cycle, advances the model.
    task automatic step(input bit v, input logic [AW-1:0] a, input logic [TW-1:0] tg,
                        input bit rr, input bit inj);
        bit   exp_ready, exp_valid, acc, pop;
        exp_t e;
        exp_ready = (occ < DEPTH);
        exp_valid = (q.size() != 0) && (q[0].vis <= cyc);
        check("req_ready",  bus.REQ_READY,  exp_ready);
        check("occupancy",  occupancy,      occ);
        check("resp_valid", bus.RESP_VALID, exp_valid);
        check("err_unexp",  err_unexp,      exp_err);
        if (exp_valid) begin
            check("resp_data", bus.RESP_DATA, q[0].ent.data);
`ifdef DPRAM_RD_CTRL_TAG_EN
            check("resp_tag", bus.RESP_TAG, q[0].ent.tag);
`endif
        end
        bus.REQ_VALID  = v;
        bus.REQ_ADDR   = a;
`ifdef DPRAM_RD_CTRL_TAG_EN
        bus.REQ_TAG    = tg;
`endif
        bus.RESP_READY = rr;
        inj_rv         = inj;
        #1;
        check("arvalid", bus.ARVALID, v && exp_ready);
        if (v) check("araddr", bus.ARADDR, a);
        if (bus.ARVALID) arv_cnt++;
        acc = v && exp_ready;
        pop = exp_valid && rr;
        if (inj && !last_acc) exp_err = 1'b1;
        if (pop) begin
            void'(q.pop_front());
            occ--;
        end
        if (acc) begin
            e.ent.data = mem[a];
`ifdef DPRAM_RD_CTRL_TAG_EN
            e.ent.tag  = tg;
`endif
            e.vis      = cyc + 2;
            q.push_back(e);
            occ++;
        end
        last_acc = acc;
        @(negedge CLK);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b1, 1'b0);
    endtask

    initial begin
        int n0;
        n_checks = 0;
        n_errors = 0;
        arv_cnt  = 0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = {$urandom, $urandom};
        mem[5] = 64'hA5;

        RESET          = 1'b0;
        bus.REQ_VALID  = 1'b0;
        bus.REQ_ADDR   = '0;
`ifdef DPRAM_RD_CTRL_TAG_EN
        bus.REQ_TAG    = '0;
`endif
        bus.RESP_READY = 1'b0;
        inj_rv         = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_occupancy",  occupancy,      0);
        check("rst_resp_valid", bus.RESP_VALID, 0);
        check("rst_req_ready",  bus.REQ_READY,  1);
        check("rst_err",        err_unexp,      0);
        RESET = 1'b1;
        model_reset();

        // Single read of address 5: response two cycles after acceptance.
        step(1'b1, 10'd5, 4'h2, 1'b1, 1'b0);
        idle(4);

        // Reset asserted while a read is in flight; its RAM response lands during reset.
        step(1'b1, 10'd33, 4'h9, 1'b1, 1'b0);
        RESET         = 1'b0;
        bus.REQ_VALID = 1'b0;
        @(negedge CLK);
        RESET = 1'b1;
        model_reset();
        check("rstmid_occupancy",  occupancy,      0);
        check("rstmid_resp_valid", bus.RESP_VALID, 0);
        check("rstmid_req_ready",  bus.REQ_READY,  1);
        idle(3);

        // Back-to-back streaming with the consumer always ready.
        for (int i = 0; i < 16; i++) begin
            check("stream_ready", bus.REQ_READY, 1);
            step(1'b1, AW'(i), TW'(i), 1'b1, 1'b0);
        end
        idle(4);

        // Backpressure: only DEPTH requests fit, then one pop frees one slot.
        n0 = arv_cnt;
        for (int i = 0; i < 8; i++) step(1'b1, AW'($urandom), TW'($urandom), 1'b0, 1'b0);
        check("bp_accepts",  arv_cnt - n0, DEPTH);
        check("bp_occupancy", occupancy,   DEPTH);
        step(1'b1, AW'($urandom), TW'($urandom), 1'b1, 1'b0);
        step(1'b1, AW'($urandom), TW'($urandom), 1'b0, 1'b0);
        check("bp_one_more", arv_cnt - n0, DEPTH + 1);
        idle(10);

        // Unexpected RVALID with nothing in flight.
        step(1'b0, '0, '0, 1'b1, 1'b1);
        idle(3);
        check("err_held", err_unexp, 1);

        // Tag ordering under random consumer readiness.
        step(1'b1, 10'd100, 4'd3, 1'($urandom), 1'b0);
        step(1'b1, 10'd101, 4'd7, 1'($urandom), 1'b0);
        step(1'b1, 10'd102, 4'd1, 1'($urandom), 1'b0);
        for (int i = 0; i < 30; i++) step(1'b0, '0, '0, 1'($urandom), 1'b0);
        idle(6);

        // Random traffic.
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, AW'($urandom), TW'($urandom),
                 $urandom_range(0, 2) != 0, 1'b0);
        idle(8);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
